// File: rtl/pcie_phy_pkg.sv
//------------------------------------------------------------------------------
// Module   : pcie_phy_pkg
// Brief    : Shared constants, FSM state type and sizing helper for the
//            transmit-path serialiser.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pcie_phy_pkg;

    // K28.5 comma byte used as the idle word on every lane.
    localparam logic [7:0] c_K28_5_IDLE = 8'hBC;

    // Link bring-up state: idle preamble first, then normal data.
    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } phy_state_t;

    // Counter width able to hold 0..n-1; never narrower than one bit so a
    // single-word preamble still gets a legal register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/paratoserial_nlane_piso_lane.sv
//------------------------------------------------------------------------------
// Module   : piso_lane
// Brief    : One serial lane: WIDTH-bit shift register that loads a word on
//            the shared word boundary and otherwise shifts toward the output
//            end with zero fill.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_lane
    import pcie_phy_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] IDLE      = WIDTH'(c_K28_5_IDLE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    output logic             serial
);

    logic [WIDTH-1:0] r_shreg;

    // Reset parks the lane on the idle word so the first preamble word is
    // already in place; otherwise load at boundaries and shift in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= IDLE;
        end else if (load) begin
            r_shreg <= load_word;
        end else if (MSB_FIRST) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    // The output tap is the end the register shifts toward.
    assign serial = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

endmodule

`default_nettype wire

// File: rtl/paratoserial_nlane.sv
//------------------------------------------------------------------------------
// Module   : paratoserial_nlane
// Brief    : Multi-lane parallel-to-serial converter. A shared bit counter
//            defines word boundaries for all lanes; after reset an idle
//            preamble is sent before data words are accepted.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module paratoserial_nlane
    import pcie_phy_pkg::*;
#(
    parameter int               LANES      = 2,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE       = WIDTH'(c_K28_5_IDLE),
    parameter int               SYNC_WORDS = 4,
    parameter bit               MSB_FIRST  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES-1:0]       lane_en,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_serial,
    output logic                   word_start,
    output logic                   synced
);

    localparam int              c_BW        = cnt_width(WIDTH);
    localparam int              c_SW        = cnt_width(SYNC_WORDS);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(WIDTH - 1);
    localparam logic [c_SW-1:0] c_SYNC_LAST = c_SW'(SYNC_WORDS - 1);

    phy_state_t       r_state;
    phy_state_t       w_state_nxt;
    logic [c_BW-1:0]  r_bit_cnt;
    logic [c_BW-1:0]  w_bit_cnt_nxt;
    logic [c_SW-1:0]  r_sync_cnt;
    logic [c_SW-1:0]  w_sync_cnt_nxt;
    logic             w_boundary;
    logic [WIDTH-1:0] w_load_word [LANES];

    // State, bit counter and preamble counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SYNC;
            r_bit_cnt  <= '0;
            r_sync_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
        end
    end

    // Next-state logic and status outputs, all derived from registered state.
    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        w_boundary     = (r_bit_cnt == c_BIT_LAST);
        w_bit_cnt_nxt  = w_boundary ? '0 : r_bit_cnt + 1'b1;

        if (r_state == ST_SYNC && w_boundary) begin
            if (r_sync_cnt == c_SYNC_LAST) begin
                // The idle word loaded on this edge is still sent; data is
                // first taken at the following boundary.
                w_state_nxt = ST_RUN;
            end else begin
                w_sync_cnt_nxt = r_sync_cnt + 1'b1;
            end
        end

        synced     = (r_state == ST_RUN);
        in_ready   = (r_state == ST_RUN) && w_boundary;
        word_start = (r_bit_cnt == '0);
    end

    // Per-lane word selection at a boundary: preamble idle, then enable,
    // then valid, then the lane's slice of in_data.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_load_word[k] = IDLE;
            if (r_state == ST_RUN) begin
                if (!lane_en[k]) begin
                    w_load_word[k] = '0;
                end else if (in_valid[k]) begin
                    w_load_word[k] = in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        piso_lane #(
            .WIDTH     (WIDTH),
            .MSB_FIRST (MSB_FIRST),
            .IDLE      (IDLE)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (w_boundary),
            .load_word (w_load_word[k]),
            .serial    (out_serial[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_paratoserial_nlane.sv
//------------------------------------------------------------------------------
// Module   : tb_paratoserial_nlane
// Brief    : Self-checking bench for paratoserial_nlane. Two instances: the
//            default configuration and a 4-lane, 10-bit, LSB-first one.
//            Expected output is computed from cycle arithmetic: word index
//            t/WIDTH, bit t%WIDTH, with sampled words kept in an array.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_paratoserial_nlane;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        rst;
    logic [15:0] dat [4];
    logic [3:0]  vld;
    logic [3:0]  en;

    int total = 0;
    int bad   = 0;

    // Active configuration of the reference model.
    int          cw;
    int          cs;
    int          cl;
    bit          cmsb;
    logic [15:0] cidle;
    int          t;
    logic [15:0] wq [128][4];

    // Default instance
    logic [15:0] a_data;
    logic [1:0]  a_ser;
    logic        a_rdy, a_ws, a_sync;
    assign a_data = {dat[1][7:0], dat[0][7:0]};

    paratoserial_nlane u_a (
        .clk        (clk),
        .reset      (rst | sel),
        .in_data    (a_data),
        .in_valid   (vld[1:0]),
        .lane_en    (en[1:0]),
        .in_ready   (a_rdy),
        .out_serial (a_ser),
        .word_start (a_ws),
        .synced     (a_sync)
    );

    // Swept instance
    logic [39:0] b_data;
    logic [3:0]  b_ser;
    logic        b_rdy, b_ws, b_sync;
    assign b_data = {dat[3][9:0], dat[2][9:0], dat[1][9:0], dat[0][9:0]};

    paratoserial_nlane #(
        .LANES      (4),
        .WIDTH      (10),
        .IDLE       (10'h17C),
        .SYNC_WORDS (2),
        .MSB_FIRST  (1'b0)
    ) u_b (
        .clk        (clk),
        .reset      (rst | ~sel),
        .in_data    (b_data),
        .in_valid   (vld),
        .lane_en    (en),
        .in_ready   (b_rdy),
        .out_serial (b_ser),
        .word_start (b_ws),
        .synced     (b_sync)
    );

    logic [3:0] obs_ser;
    logic       obs_rdy, obs_ws, obs_sync;
    assign obs_ser  = sel ? b_ser  : {2'b00, a_ser};
    assign obs_rdy  = sel ? b_rdy  : a_rdy;
    assign obs_ws   = sel ? b_ws   : a_ws;
    assign obs_sync = sel ? b_sync : a_sync;

    // Word a lane takes at a data boundary, from the current inputs.
    function automatic logic [15:0] rule_word(input int k);
        logic [15:0] mask;
        mask = (16'h1 << cw) - 16'h1;
        if (!en[k])  return 16'h0000;
        if (!vld[k]) return cidle;
        return dat[k] & mask;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0b expected=%0b", tag, t, obs, exp);
        end
    endtask

    // Compare every output for model cycle t.
    task automatic check_cycle();
        int          w;
        int          b;
        logic [15:0] word;
        w = t / cw;
        b = t % cw;
        check("in_ready",   obs_rdy,  (t >= cs*cw) && (b == cw-1));
        check("word_start", obs_ws,   b == 0);
        check("synced",     obs_sync, t >= cs*cw);
        for (int k = 0; k < cl; k++) begin
            word = (w <= cs) ? cidle : wq[w][k];
            check($sformatf("serial%0d", k), obs_ser[k],
                  cmsb ? word[cw-1-b] : word[b]);
        end
    endtask

    // One clock with current inputs; r=1 applies reset on this edge.
    task automatic cycle(input logic r);
        rst = r;
        if (!r && t >= cs*cw && (t % cw) == cw-1 && (t / cw + 1) < 128) begin
            for (int k = 0; k < cl; k++) begin
                wq[t/cw + 1][k] = rule_word(k);
            end
        end
        @(posedge clk);
        if (r) t = 0;
        else   t++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic word2(input logic [7:0] d1, input logic [7:0] d0,
                         input logic [1:0] v, input logic [1:0] e);
        dat[1] = {8'h00, d1};
        dat[0] = {8'h00, d0};
        vld    = {2'b00, v};
        en     = {2'b00, e};
        repeat (cw) cycle(1'b0);
    endtask

    task automatic rand_cycle();
        for (int k = 0; k < 4; k++) dat[k] = 16'($urandom);
        vld = 4'($urandom);
        en  = 4'($urandom | $urandom);
        cycle(1'b0);
    endtask

    initial begin
        sel   = 1'b0;
        rst   = 1'b1;
        t     = 0;
        cw    = 8;
        cs    = 4;
        cl    = 2;
        cmsb  = 1'b1;
        cidle = 16'h00BC;
        for (int k = 0; k < 4; k++) dat[k] = 16'h00FF;
        vld = 4'hF;
        en  = 4'hF;

        // Reset, preamble, FF sampled at cycle 39
        repeat (3) cycle(1'b1);
        repeat (40) cycle(1'b0);

        // Back-to-back data, per-lane valid, lane enable
        word2(8'hAA, 8'hAA, 2'b11, 2'b11);
        word2(8'hEE, 8'hEE, 2'b11, 2'b11);
        word2(8'hEE, 8'hEE, 2'b11, 2'b11);
        word2(8'hBB, 8'hCC, 2'b10, 2'b11);
        word2(8'hFF, 8'hEE, 2'b11, 2'b01);
        word2(8'h5A, 8'hC3, 2'b11, 2'b11);

        // Reset at bit 3 of a data word, then a fresh preamble and random data
        repeat (3) cycle(1'b0);
        repeat (2) cycle(1'b1);
        repeat (136) rand_cycle();

        // Swept configuration: 4 lanes, 10 bits, LSB first, 2-word preamble
        sel   = 1'b1;
        cw    = 10;
        cs    = 2;
        cl    = 4;
        cmsb  = 1'b0;
        cidle = 16'h017C;
        repeat (2) cycle(1'b1);
        repeat (200) rand_cycle();
        repeat (4) cycle(1'b0);
        repeat (3) cycle(1'b1);
        repeat (60) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
